coe_buf_ctrl: RTL

COE_BUF_CTRL -- requirements
Module: coe_buf_ctrl

---
 rtl/coe_buf_ctrl_pkg.sv | 32 +++
 rtl/coe_buf_ctrl_ram.sv | 34 +++
 rtl/coe_buf_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/coe_buf_ctrl_pkg.sv
// Shared constants for the coefficient ping-pong buffer controller.
// PIXEL_WIDTH normally comes from enc_defines.v in the encoder build; the
// fallback below keeps this slice self-contained when that file is absent.
`ifndef PIXEL_WIDTH
`define PIXEL_WIDTH 8
`endif

package coe_buf_ctrl_pkg;

   localparam int PIX_W          = `PIXEL_WIDTH;
   localparam int HALF_W         = PIX_W * 4;
   localparam int ROW_W          = PIX_W * 8;
   localparam int N_BANKS        = 2;
   localparam int N_ROWS         = 32;
   localparam int ROW_AW         = 5;
   localparam int BEATS_PER_BANK = 2 * N_ROWS;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic             last;
      logic [ROW_W-1:0] dat;
   } fifo_ent_t;

   // Even beats land in the low half of a row, odd beats in the high half.
   function automatic logic [1:0] half_we(input logic odd);
      return odd ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/coe_buf_ctrl_ram.sv
// One coefficient bank: 32 rows, two-port, half-row write enables on port A,
// registered (1-cycle) read on port B. Contents are never reset.
module buf_ram_2p_64x32 #(
   parameter int DW = 64,
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic [1:0]    wen_a,
   input  logic [AW-1:0] addr_a,
   input  logic [DW-1:0] din_a,
   input  logic          ren_b,
   input  logic [AW-1:0] addr_b,
   output logic [DW-1:0] dout_b
);

   localparam int HW = DW / 2;

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] dout_q;

   // Port A: independent writes of the low and high half of a row.
   always_ff @(posedge clk) begin
      if (wen_a[0]) mem_q[addr_a][HW-1:0] <= din_a[HW-1:0];
      if (wen_a[1]) mem_q[addr_a][DW-1:HW] <= din_a[DW-1:HW];
   end

   // Port B: registered read, data valid the cycle after ren_b.
   always_ff @(posedge clk) begin
      if (ren_b) dout_q <= mem_q[addr_b];
   end

   assign dout_b = dout_q;

endmodule

// File: rtl/coe_buf_ctrl.sv
// Ping-pong coefficient buffer: half-rows in, full rows out, two 32-row banks.
// Optional per-bank coded-block flag enabled by defining COE_BUF_CBF_EN;
// without it rd_cbf_o is tied high.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting for bank rsel to become full
// ST_RUN   | issuing row reads 0..31 of bank rsel, throttled by FIFO room
// ST_DRAIN | all rows issued; waiting for the last row to be accepted
module coe_buf_ctrl
   import coe_buf_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rstn,
   input  logic              flush_i,
   input  logic              wr_val_i,
   input  logic [HALF_W-1:0] wr_dat_i,
   output logic              wr_rdy_o,
   output logic              rd_val_o,
   output logic [ROW_W-1:0]  rd_dat_o,
   output logic              rd_last_o,
   input  logic              rd_rdy_i,
   output logic              rd_cbf_o
);

   logic [N_BANKS-1:0] full_q, full_d;
   logic               wsel_q, wsel_d;
   logic               rsel_q, rsel_d;
   logic [5:0]         wcnt_q, wcnt_d;
   logic [1:0]         state_q, state_d;
   logic [ROW_AW-1:0]  rcnt_q, rcnt_d;
   logic               infl_q, infl_d;
   logic               infl_last_q, infl_last_d;
   fifo_ent_t          fifo_q [2];
   fifo_ent_t          fifo_d [2];
   logic               fifo_wp_q, fifo_wp_d;
   logic               fifo_rp_q, fifo_rp_d;
   logic [1:0]         fifo_cnt_q, fifo_cnt_d;

   logic                          wr_fire;
   logic                          bank_done;
   logic                          pop;
   logic                          rd_issue;
   logic                          drain_done;
   logic [2:0]                    occ;
   fifo_ent_t                     head;
   logic [N_BANKS-1:0][1:0]       ram_wen;
   logic [N_BANKS-1:0]            ram_ren;
   logic [ROW_W-1:0]              ram_q [N_BANKS];

   // Handshakes, FIFO head and read-issue throttle.
   always_comb begin
      wr_rdy_o   = !full_q[wsel_q];
      wr_fire    = wr_val_i && wr_rdy_o && rstn && !flush_i;
      bank_done  = wr_fire && (wcnt_q == 6'(BEATS_PER_BANK - 1));
      head       = fifo_q[fifo_rp_q];
      rd_val_o   = (fifo_cnt_q != 2'd0);
      rd_dat_o   = rd_val_o ? head.dat : '0;
      rd_last_o  = rd_val_o && head.last;
      pop        = rd_val_o && rd_rdy_i;
      // Occupancy after this edge counting the read already in the RAM pipe.
      occ        = {1'b0, fifo_cnt_q} - {2'b00, pop} + {2'b00, infl_q};
      rd_issue   = (state_q == ST_RUN) && (occ < 3'd2);
      drain_done = (state_q == ST_DRAIN) && pop && head.last;
   end

   // Per-bank RAM strobes: writes go to wsel, reads come from rsel.
   always_comb begin
      ram_wen = '0;
      ram_ren = '0;
      if (wr_fire) ram_wen[wsel_q] = half_we(wcnt_q[0]);
      ram_ren[rsel_q] = rd_issue;
   end

   for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
      buf_ram_2p_64x32 #(
         .DW (ROW_W),
         .AW (ROW_AW)
      ) u_ram (
         .clk    (clk),
         .wen_a  (ram_wen[g]),
         .addr_a (wcnt_q[5:1]),
         .din_a  ({wr_dat_i, wr_dat_i}),
         .ren_b  (ram_ren[g]),
         .addr_b (rcnt_q),
         .dout_b (ram_q[g])
      );
   end

   // Next-state: write counter, bank pointers, full bits, read FSM and FIFO.
   always_comb begin
      full_d      = full_q;
      wsel_d      = wsel_q;
      rsel_d      = rsel_q;
      wcnt_d      = wcnt_q;
      state_d     = state_q;
      rcnt_d      = rcnt_q;
      infl_d      = rd_issue;
      infl_last_d = (rcnt_q == ROW_AW'(N_ROWS - 1));
      fifo_d      = fifo_q;
      fifo_wp_d   = fifo_wp_q;
      fifo_rp_d   = fifo_rp_q;
      fifo_cnt_d  = fifo_cnt_q + {1'b0, infl_q} - {1'b0, pop};

      if (wr_fire) begin
         // 6-bit counter wraps to 0 on its own after beat 63.
         wcnt_d = wcnt_q + 6'd1;
         if (bank_done) begin
            full_d[wsel_q] = 1'b1;
            wsel_d         = !wsel_q;
         end
      end

      case (state_q)
         ST_IDLE: begin
            if (full_q[rsel_q]) begin
               state_d = ST_RUN;
               rcnt_d  = '0;
            end
         end
         ST_RUN: begin
            if (rd_issue) begin
               rcnt_d = rcnt_q + 1'b1;
               if (rcnt_q == ROW_AW'(N_ROWS - 1)) state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            // The writer never targets rsel while it is full, so this clear
            // cannot collide with a set of the same bit.
            if (drain_done) begin
               state_d        = ST_IDLE;
               full_d[rsel_q] = 1'b0;
               rsel_d         = !rsel_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (infl_q) begin
         fifo_d[fifo_wp_q] = '{last: infl_last_q, dat: ram_q[rsel_q]};
         fifo_wp_d         = !fifo_wp_q;
      end
      if (pop) fifo_rp_d = !fifo_rp_q;

      if (flush_i) begin
         full_d      = '0;
         wsel_d      = 1'b0;
         rsel_d      = 1'b0;
         wcnt_d      = '0;
         state_d     = ST_IDLE;
         rcnt_d      = '0;
         infl_d      = 1'b0;
         infl_last_d = 1'b0;
         fifo_wp_d   = 1'b0;
         fifo_rp_d   = 1'b0;
         fifo_cnt_d  = '0;
      end
   end

   // Control state registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         full_q      <= '0;
         wsel_q      <= 1'b0;
         rsel_q      <= 1'b0;
         wcnt_q      <= '0;
         state_q     <= ST_IDLE;
         rcnt_q      <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         fifo_wp_q   <= 1'b0;
         fifo_rp_q   <= 1'b0;
         fifo_cnt_q  <= '0;
      end else begin
         full_q      <= full_d;
         wsel_q      <= wsel_d;
         rsel_q      <= rsel_d;
         wcnt_q      <= wcnt_d;
         state_q     <= state_d;
         rcnt_q      <= rcnt_d;
         infl_q      <= infl_d;
         infl_last_q <= infl_last_d;
         fifo_wp_q   <= fifo_wp_d;
         fifo_rp_q   <= fifo_rp_d;
         fifo_cnt_q  <= fifo_cnt_d;
      end
   end

   // FIFO payload needs no reset; outputs are masked by rd_val_o.
   always_ff @(posedge clk) begin
      fifo_q <= fifo_d;
   end

`ifdef COE_BUF_CBF_EN
   logic [N_BANKS-1:0] cbf_q, cbf_d;

   // Coded-block flag per bank: restart on beat 0, sticky on nonzero data.
   always_comb begin
      cbf_d = cbf_q;
      if (wr_fire) begin
         if (wcnt_q == 6'd0)     cbf_d[wsel_q] = |wr_dat_i;
         else if (|wr_dat_i)     cbf_d[wsel_q] = 1'b1;
      end
      if (flush_i) cbf_d = '0;
   end

   // Flag registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (!rstn) cbf_q <= '0;
      else       cbf_q <= cbf_d;
   end

   // Bank rsel is full while being read, so its flag cannot move mid-stall.
   assign rd_cbf_o = rd_val_o && cbf_q[rsel_q];
`else
   assign rd_cbf_o = 1'b1;
`endif

endmodule
